// File: rtl/result_uart_formatter_pkg.sv
// Shared definitions for the result-to-UART formatter: FSM states, ASCII
// byte constants and the power-of-ten table used by the digit converter.
package result_uart_formatter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CONV,
    ST_SIGN,
    ST_DIGIT,
    ST_SUFFIX,
    ST_CR,
    ST_LF
  } state_t;

  localparam logic [7:0] ASCII_MINUS = 8'h2D;
  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_R     = 8'h52;

  // 10^k for k in 0..9; the fixed loop bound keeps this a plain mux tree.
  function automatic logic [31:0] pow10(input int k);
    logic [31:0] p;
    p = 32'd1;
    for (int i = 0; i < 9; i++) begin
      if (i < k) p = p * 32'd10;
    end
    return p;
  endfunction

endpackage

// File: rtl/result_uart_formatter_dec_digit_serial.sv
// dec_digit_serial: binary-to-BCD conversion by repeated subtraction of
// powers of ten, most significant power first. One subtraction or one
// power step per cycle; done is raised combinationally in the last cycle.
module dec_digit_serial #(
  parameter int W      = 12,
  parameter int DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [W-1:0]            mag,
  output logic [DIGITS-1:0][3:0]  digits,
  output logic                    done
);
  import result_uart_formatter_pkg::*;

  localparam int KW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic          running;
  logic [W-1:0]  rem;
  logic [KW-1:0] k;
  logic [31:0]   rem_ext;
  logic [31:0]   step;
  logic          ge;

  assign rem_ext = 32'(rem);
  assign step    = pow10(int'(k));
  assign ge      = (rem_ext >= step);
  assign done    = running && !ge && (k == '0);

  // Subtract the current power while it fits, otherwise move to the next lower power.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      running <= 1'b0;
      rem     <= '0;
      k       <= '0;
      digits  <= '0;
    end else if (start) begin
      running <= 1'b1;
      rem     <= mag;
      k       <= KW'(DIGITS - 1);
      digits  <= '0;
    end else if (running) begin
      if (ge) begin
        rem       <= rem - step[W-1:0];
        digits[k] <= digits[k] + 4'd1;
      end else if (k == '0) begin
        running <= 1'b0;
      end else begin
        k <= k - 1'b1;
      end
    end
  end

endmodule

// File: rtl/result_uart_formatter.sv
// result_uart_formatter: captures a signed result and writes it to the UART
// TX FIFO as decimal ASCII ('-', digits without leading zeros, CR LF).
// Optional build macro RMD_SUFFIX_EN appends " R" when the remainder flag
// was set. DIGITS must satisfy 10^DIGITS > 2^(W-1).
module result_uart_formatter #(
  parameter int W      = 12,
  parameter int DIGITS = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         valid,
  input  logic [W-1:0] q,
  input  logic         rmd,
  input  logic         tx_full,
  output logic         wr_en,
  output logic [7:0]   wr_data,
  output logic         busy,
  output logic         done_tick,
  output logic         overrun_tick
);
  import result_uart_formatter_pkg::*;

  localparam int KW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  state_t                 state;
  state_t                 state_next;
  logic                   sign_r;
  logic [KW-1:0]          ptr;
  logic [KW-1:0]          ptr_next;
  logic [KW-1:0]          first_nz;
  logic [W-1:0]           abs_q;
  logic                   conv_start;
  logic                   conv_done;
  logic [DIGITS-1:0][3:0] digits;
  state_t                 after_digits;

`ifdef RMD_SUFFIX_EN
  logic rmd_r;
  logic suf_idx;
  logic suf_idx_next;
  assign after_digits = rmd_r ? ST_SUFFIX : ST_CR;
`else
  logic unused_rmd;
  assign unused_rmd   = rmd;
  assign after_digits = ST_CR;
`endif

  // Two's-complement magnitude; the most negative value maps to 2^(W-1) unsigned.
  assign abs_q = q[W-1] ? (~q + W'(1)) : q;

  assign busy         = (state != ST_IDLE);
  assign overrun_tick = valid && (state != ST_IDLE);

  dec_digit_serial #(
    .W      (W),
    .DIGITS (DIGITS)
  ) u_conv (
    .clk    (clk),
    .reset  (reset),
    .start  (conv_start),
    .mag    (abs_q),
    .digits (digits),
    .done   (conv_done)
  );

  // Locate the most significant nonzero digit; all-zero results point at digit 0.
  always_comb begin
    first_nz = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (digits[i] != 4'd0) first_nz = KW'(i);
    end
  end

  // State, digit pointer and captured sign/remainder registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= ST_IDLE;
      ptr    <= '0;
      sign_r <= 1'b0;
`ifdef RMD_SUFFIX_EN
      rmd_r   <= 1'b0;
      suf_idx <= 1'b0;
`endif
    end else begin
      state <= state_next;
      ptr   <= ptr_next;
      if (conv_start) begin
        sign_r <= q[W-1];
`ifdef RMD_SUFFIX_EN
        rmd_r <= rmd;
`endif
      end
`ifdef RMD_SUFFIX_EN
      suf_idx <= suf_idx_next;
`endif
    end
  end

  // Byte sequencing: each emitting state writes only when the FIFO has room.
  always_comb begin
    state_next = state;
    ptr_next   = ptr;
    wr_en      = 1'b0;
    wr_data    = 8'h00;
    done_tick  = 1'b0;
    conv_start = 1'b0;
`ifdef RMD_SUFFIX_EN
    suf_idx_next = suf_idx;
`endif
    case (state)
      ST_IDLE: begin
        if (valid) begin
          conv_start = 1'b1;
          state_next = ST_CONV;
        end
      end
      ST_CONV: begin
        if (conv_done) begin
          ptr_next   = first_nz;
          state_next = sign_r ? ST_SIGN : ST_DIGIT;
        end
      end
      ST_SIGN: begin
        if (!tx_full) begin
          wr_en      = 1'b1;
          wr_data    = ASCII_MINUS;
          state_next = ST_DIGIT;
        end
      end
      ST_DIGIT: begin
        if (!tx_full) begin
          wr_en   = 1'b1;
          wr_data = ASCII_ZERO + {4'd0, digits[ptr]};
          if (ptr == '0) begin
            state_next = after_digits;
`ifdef RMD_SUFFIX_EN
            suf_idx_next = 1'b0;
`endif
          end else begin
            ptr_next = ptr - 1'b1;
          end
        end
      end
      ST_SUFFIX: begin
`ifdef RMD_SUFFIX_EN
        if (!tx_full) begin
          wr_en = 1'b1;
          if (suf_idx) begin
            wr_data      = ASCII_R;
            suf_idx_next = 1'b0;
            state_next   = ST_CR;
          end else begin
            wr_data      = ASCII_SPACE;
            suf_idx_next = 1'b1;
          end
        end
`else
        state_next = ST_CR;
`endif
      end
      ST_CR: begin
        if (!tx_full) begin
          wr_en      = 1'b1;
          wr_data    = ASCII_CR;
          state_next = ST_LF;
        end
      end
      ST_LF: begin
        if (!tx_full) begin
          wr_en      = 1'b1;
          wr_data    = ASCII_LF;
          done_tick  = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_result_uart_formatter.sv
// Self-checking bench for result_uart_formatter: directed cases plus random
// results and random FIFO back-pressure, checked against a string model.
module tb_result_uart_formatter;

  localparam int W      = 12;
  localparam int DIGITS = 4;
`ifdef RMD_SUFFIX_EN
  localparam bit SUFFIX_ON = 1'b1;
`else
  localparam bit SUFFIX_ON = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic         valid;
  logic [W-1:0] q;
  logic         rmd;
  logic         tx_full;
  logic         wr_en;
  logic [7:0]   wr_data;
  logic         busy;
  logic         done_tick;
  logic         overrun_tick;

  int errors = 0;
  int checks = 0;
  logic [7:0] rx[$];
  int done_count = 0;
  int ov_count = 0;
  int stall_viol = 0;
  int done_misaligned = 0;

  result_uart_formatter #(
    .W      (W),
    .DIGITS (DIGITS)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .valid        (valid),
    .q            (q),
    .rmd          (rmd),
    .tx_full      (tx_full),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .busy         (busy),
    .done_tick    (done_tick),
    .overrun_tick (overrun_tick)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Capture written bytes and pulse events midway between clock edges.
  always @(negedge clk) begin
    if (wr_en) rx.push_back(wr_data);
    if (wr_en && tx_full) stall_viol++;
    if (done_tick) begin
      done_count++;
      if (!(wr_en && wr_data == 8'h0A)) done_misaligned++;
    end
    if (overrun_tick) ov_count++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference line: signed decimal text, optional suffix, CR LF.
  function automatic string expectLine(input logic [W-1:0] qv, input logic rv);
    int    v;
    string s;
    v = int'($signed(qv));
    s = $sformatf("%0d", v);
    if (SUFFIX_ON && rv) s = {s, " R"};
    s = {s, "\r\n"};
    return s;
  endfunction

  // mode 0: FIFO never full; 1: random full; 2: full for 5 cycles after first byte.
  task automatic applyStimulus(input logic [W-1:0] qv, input logic rv, input int mode,
                               input int overrun_at, input string name);
    int    start_done;
    int    start_ov;
    int    start_viol;
    int    start_mis;
    int    forced;
    bit    finished;
    string exp;
    exp        = expectLine(qv, rv);
    rx.delete();
    start_done = done_count;
    start_ov   = ov_count;
    start_viol = stall_viol;
    start_mis  = done_misaligned;
    forced     = 0;
    finished   = 1'b0;
    @(posedge clk); #1;
    valid   = 1'b1;
    q       = qv;
    rmd     = rv;
    tx_full = 1'b0;
    for (int c = 1; c <= 400; c++) begin
      @(posedge clk); #1;
      if (done_count != start_done) begin
        finished = 1'b1;
        valid    = 1'b0;
        tx_full  = 1'b0;
        break;
      end
      valid = (c == overrun_at);
      q     = (c == overrun_at) ? W'(9) : W'($urandom);
      rmd   = 1'($urandom);
      case (mode)
        1: tx_full = ($urandom_range(0, 2) == 0);
        2: begin
          if (rx.size() >= 1 && forced < 5) begin
            tx_full = 1'b1;
            forced++;
          end else begin
            tx_full = 1'b0;
          end
        end
        default: tx_full = 1'b0;
      endcase
    end
    checkOutput({name, " done"}, 32'(finished), 32'd1);
    checkOutput({name, " busy_after"}, 32'(busy), 32'd0);
    checkOutput({name, " len"}, 32'(rx.size()), 32'(exp.len()));
    for (int i = 0; i < exp.len(); i++) begin
      if (i < rx.size())
        checkOutput($sformatf("%s byte%0d", name, i), 32'(rx[i]), 32'(exp[i]));
    end
    checkOutput({name, " overrun"}, 32'(ov_count - start_ov), (overrun_at > 0) ? 32'd1 : 32'd0);
    checkOutput({name, " stall_write"}, 32'(stall_viol - start_viol), 32'd0);
    checkOutput({name, " done_align"}, 32'(done_misaligned - start_mis), 32'd0);
  endtask

  initial begin
    reset   = 1'b1;
    valid   = 1'b0;
    q       = '0;
    rmd     = 1'b0;
    tx_full = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst wr_en", 32'(wr_en), 32'd0);
    checkOutput("rst wr_data", 32'(wr_data), 32'd0);
    checkOutput("rst busy", 32'(busy), 32'd0);
    checkOutput("rst done_tick", 32'(done_tick), 32'd0);
    checkOutput("rst overrun", 32'(overrun_tick), 32'd0);
    reset = 1'b0;
    repeat (2) @(posedge clk);

    applyStimulus(W'(0), 1'b0, 0, -1, "zero");
    applyStimulus(W'(-123), 1'b0, 0, -1, "m123");
    applyStimulus(W'(-2048), 1'b0, 0, -1, "m2048");
    applyStimulus(W'(2047), 1'b0, 0, -1, "p2047");
    applyStimulus(W'(45), 1'b0, 2, -1, "stall45");
    applyStimulus(W'(7), 1'b0, 0, 3, "overrun7");
    applyStimulus(W'(3), 1'b1, 0, -1, "sfx3r1");
    applyStimulus(W'(3), 1'b0, 0, -1, "sfx3r0");
    applyStimulus(W'(100), 1'b1, 1, -1, "p100");

    for (int n = 0; n < 30; n++) begin
      applyStimulus(W'($urandom), 1'($urandom), int'($urandom_range(0, 1)), -1, "rand");
    end

    // Reset right after the '-' of -5 must abort the line.
    rx.delete();
    @(posedge clk); #1;
    valid = 1'b1;
    q     = W'(-5);
    for (int c = 0; c < 100; c++) begin
      @(posedge clk); #1;
      valid = 1'b0;
      if (rx.size() >= 1) break;
    end
    reset = 1'b1;
    #1;
    checkOutput("midrst wr_en", 32'(wr_en), 32'd0);
    checkOutput("midrst wr_data", 32'(wr_data), 32'd0);
    checkOutput("midrst busy", 32'(busy), 32'd0);
    checkOutput("midrst done_tick", 32'(done_tick), 32'd0);
    checkOutput("midrst overrun", 32'(overrun_tick), 32'd0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    checkOutput("midrst len", 32'(rx.size()), 32'd1);
    if (rx.size() >= 1) checkOutput("midrst minus", 32'(rx[0]), 32'h2D);
    checkOutput("midrst idle", 32'(busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
